// File: rtl/dup_word_filter_if.sv
// Stream bundle between the upstream producer, dup_word_filter and its consumer.
//
// Handshake: a word moves on a side exactly in a cycle where that side's
// valid and ready are both high at the rising clock edge. A source holds
// valid and data steady until the transfer happens. in_ready never depends
// on in_valid.
interface dup_word_filter_if #(
    parameter int WIDTH = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    // Producer/consumer side (drives the input word and the output ready)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Filter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dup_word_filter.sv
// Duplicate-word filter: drops any input word equal to one of the last DEPTH
// distinct words forwarded, registers survivors on the output, and keeps a
// saturating count of the dropped words.
module dup_word_filter #(
    parameter int  WIDTH = 4,
    parameter int  DEPTH = 4,
    parameter int  CNTW  = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    dup_word_filter_if.slave bus,
    output logic             dup_pulse,
    output logic [CNTW-1:0]  drop_count,
    output logic             dbg_state,
    output logic [PW-1:0]    dbg_wp
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t        state_q, state_d;
    logic [WIDTH-1:0]  out_data_q;
    logic [WIDTH-1:0]  hist_data [DEPTH];
    logic [DEPTH-1:0]  hist_vld;
    logic [PW-1:0]     wp;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     wp_nxt;
    logic              hit;
    logic              accept;
    logic              unique_acc;
    logic              dup_acc;

    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_data  = out_data_q;
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;

    // Parallel compare against every live history entry (pre-update contents)
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hist_vld[i] && (hist_data[i] == bus.in_data)) begin
                hit = 1'b1;
            end
        end
    end

    // A flush empties the history, so a word accepted alongside it is unique
    assign dup_acc    = accept && hit && !flush;
    assign unique_acc = accept && !dup_acc;

    // Flush rewinds the write slot to 0 for a same-cycle write
    always_comb begin
        wr_idx = flush ? '0 : wp;
        wp_nxt = (DEPTH == 1) ? '0 : wr_idx + PW'(1);
    end

    // Output register state: next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (unique_acc) state_d = ST_FULL;
            ST_FULL: begin
                if (unique_acc)         state_d = ST_FULL;
                else if (bus.out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output register state, held word, drop pulse and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            dup_pulse  <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q   <= state_d;
            dup_pulse <= dup_acc;
            if (unique_acc) out_data_q <= bus.in_data;
            if (dup_acc && (drop_count != {CNTW{1'b1}})) begin
                drop_count <= drop_count + CNTW'(1);
            end
        end
    end

    // History valid bits and FIFO write pointer (oldest entry overwritten first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_vld <= '0;
            wp       <= '0;
        end else begin
            if (flush) begin
                hist_vld <= '0;
                wp       <= '0;
            end
            if (unique_acc) begin
                hist_vld[wr_idx] <= 1'b1;
                wp               <= wp_nxt;
            end
        end
    end

    // History words; only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (unique_acc) hist_data[wr_idx] <= bus.in_data;
    end

    assign dbg_state = (state_q == ST_FULL);
    assign dbg_wp    = wp;

endmodule

// File: tb/tb_dup_word_filter.sv
// Bench for dup_word_filter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dup_word_filter;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 2;
  localparam int PW = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic          dup_pulse;
  logic [CW-1:0] drop_count;
  logic          dbg_state;
  logic [PW-1:0] dbg_wp;

  dup_word_filter_if #(.WIDTH(W)) bus ();

  dup_word_filter #(.WIDTH(W), .DEPTH(D), .CNTW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .dup_pulse  (dup_pulse),
    .drop_count (drop_count),
    .dbg_state  (dbg_state),
    .dbg_wp     (dbg_wp)
  );

  int nvec = 0;
  int errs = 0;
  bit chk_en = 0;
  bit trace_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_valid = 0;
  logic [W-1:0] m_data  = '0;
  logic         m_pulse = 0;
  int           m_count = 0;
  int           m_wr    = 0;
  logic [W-1:0] hist_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [2:0]   trace_q[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy, acc, hit;
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_pulse = 0; m_count = 0; m_wr = 0;
      hist_q.delete();
      exp_q.delete();
    end else begin
      rdy = !m_valid || bus.out_ready;
      acc = bus.in_valid && rdy;
      hit = 0;
      if (flush) begin
        hist_q.delete();
        m_wr = 0;
      end else begin
        foreach (hist_q[i]) if (hist_q[i] == bus.in_data) hit = 1;
      end
      m_pulse = acc && hit;
      if (acc && hit && m_count < (1 << CW) - 1) m_count++;
      if (m_valid && bus.out_ready) m_valid = 0;
      if (acc && !hit) begin
        m_valid = 1;
        m_data  = bus.in_data;
        exp_q.push_back(bus.in_data);
        hist_q.push_back(bus.in_data);
        if (hist_q.size() > D) void'(hist_q.pop_front());
        m_wr = (m_wr + 1) % D;
      end
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   bus.in_ready, !m_valid || bus.out_ready);
      chk("out_valid",  bus.out_valid, m_valid);
      chk("out_data",   bus.out_data, m_data);
      chk("dup_pulse",  dup_pulse, m_pulse);
      chk("drop_count", drop_count, m_count);
      chk("wp",         dbg_wp, m_wr);
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sb_word", bus.out_data, exp_q.pop_front());
      end
      if (trace_en) trace_q.push_back({dup_pulse, drop_count});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bus.in_valid = 0;
    flush = 0;
    rst_n = 0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic send(input logic [W-1:0] w, input logic f);
    bit done = 0;
    bit r;
    bus.in_valid = 1;
    bus.in_data  = w;
    flush        = f;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #2;
      if (r) done = 1;
    end
    bus.in_valid = 0;
    flush = 0;
    chk("send_done", done, 1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- literal expectations ----------------
  int t1_exp[3] = '{3, 5, 7};
  int t2_exp[6] = '{1, 2, 3, 4, 5, 1};
  int t5_cnt[8] = '{0, 0, 1, 2, 3, 3, 3, 3};
  int t5_pul[8] = '{0, 0, 1, 1, 1, 1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.out_ready = 1;
    #1;
    do_reset();
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_out_data",   bus.out_data, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_dup_pulse",  dup_pulse, 0);
    chk("rst_in_ready",   bus.in_ready, 1);
    chk("rst_wp",         dbg_wp, 0);

    // 3,5,3,7 -> 3,5,7 forwarded, one drop
    got_q.delete(); trace_q.delete(); trace_en = 1;
    send(3, 0); send(5, 0); send(3, 0); send(7, 0);
    idle(3);
    trace_en = 0;
    chk("t1_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) if (i < got_q.size()) chk("t1_word", got_q[i], t1_exp[i]);
    chk("t1_drops", drop_count, 1);
    pulses = 0;
    foreach (trace_q[i]) if (trace_q[i][2]) pulses++;
    chk("t1_pulses", pulses, 1);

    // FIFO eviction: 1 evicted by 5, so the final 1 is forwarded
    do_reset();
    got_q.delete();
    send(1, 0); send(2, 0); send(3, 0); send(4, 0); send(5, 0); send(1, 0);
    idle(2);
    chk("t2_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) if (i < got_q.size()) chk("t2_word", got_q[i], t2_exp[i]);
    chk("t2_drops", drop_count, 0);
    chk("t2_wp", dbg_wp, 2);

    // Backpressure: held word stable, input blocked
    got_q.delete();
    bus.out_ready = 0;
    send(8, 0);
    bus.in_valid = 1;
    bus.in_data  = 9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_ready", bus.in_ready, 0);
      chk("t3_hold_data",  bus.out_data, 8);
      chk("t3_hold_valid", bus.out_valid, 1);
    end
    @(posedge clk); #2;
    bus.out_ready = 1;
    @(negedge clk);
    chk("t3_rel_ready", bus.in_ready, 1);
    @(posedge clk); #2;
    bus.in_valid = 0;
    @(negedge clk);
    chk("t3_next_valid", bus.out_valid, 1);
    chk("t3_next_data",  bus.out_data, 9);
    chk("t3_first_out",  got_q.size() > 0 ? got_q[0] : 4'hF, 8);
    idle(2);

    // Flush with a same-cycle accept
    do_reset();
    got_q.delete();
    send(9, 0); send(9, 1);
    idle(2);
    chk("t4_fwd", got_q.size(), 2);
    chk("t4_drops0", drop_count, 0);
    send(9, 0);
    idle(2);
    chk("t4_drops1", drop_count, 1);
    chk("t4_fwd_after", got_q.size(), 2);

    // Counter saturation at CNTW=2
    do_reset();
    trace_q.delete(); trace_en = 1;
    for (int i = 0; i < 6; i++) send(6, 0);
    idle(2);
    trace_en = 0;
    chk("t5_trace_len", trace_q.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      if (i < trace_q.size()) begin
        chk("t5_count", trace_q[i][1:0], t5_cnt[i]);
        chk("t5_pulse", trace_q[i][2], t5_pul[i]);
      end
    end

    // Asynchronous reset mid-stream
    do_reset();
    send(4, 0); send(4, 0); send(4, 0); send(11, 0);
    bus.out_ready = 0;
    #1;
    chk("t6_pre_valid", bus.out_valid, 1);
    chk("t6_pre_drops", drop_count, 2);
    rst_n = 0;
    #1;
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_drops", drop_count, 0);
    chk("t6_async_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    bus.out_ready = 1;
    got_q.delete();
    send(4, 0);
    idle(2);
    chk("t6_refwd_count", got_q.size(), 1);
    chk("t6_refwd_word", got_q.size() > 0 ? got_q[0] : 4'hF, 4);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
